// File: rtl/ibr_opmode_stream.sv
// Streaming ECB/CBC/CTR/OFB mode engine for the IBR block-cipher family.
// Optional define IBR_OPMODE_CNT_EN adds the blk_cnt block counter port.
//
// state   | meaning
// S_IDLE  | waiting for a buffered block; pops it into the working register
// S_ISSUE | one-cycle core_req pulse, core_din already stable
// S_WAIT  | core busy; core_din held until core_done
// S_OUT   | result presented on out_data until accepted
module ibr_opmode_stream #(
  parameter int BLK_W      = 128,
  parameter int CTR_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  input  logic             in_first,
  input  logic [1:0]       mode,
  input  logic             encrypt,
  input  logic [BLK_W-1:0] iv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             core_req,
  output logic             core_encrypt,
  output logic [BLK_W-1:0] core_din,
  input  logic [BLK_W-1:0] core_dout,
  input  logic             core_done
`ifdef IBR_OPMODE_CNT_EN
  ,
  output logic [15:0]      blk_cnt
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FIFO_FULL = (AW + 1)'(FIFO_DEPTH);
  // Selects the low CTR_W counter bits; also correct when CTR_W == BLK_W.
  localparam logic [BLK_W-1:0] CTR_MASK = (BLK_W'(1) << CTR_W) - BLK_W'(1);

  localparam logic [1:0] M_ECB = 2'd0;
  localparam logic [1:0] M_CBC = 2'd1;
  localparam logic [1:0] M_CTR = 2'd2;
  localparam logic [1:0] M_OFB = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [BLK_W:0]   r_fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [BLK_W:0]   w_head;
  logic             w_head_first;
  logic [BLK_W-1:0] w_head_data;

  logic [BLK_W-1:0] r_work;
  logic             r_work_first;
  logic [BLK_W-1:0] r_chain;
  logic [1:0]       r_mode;
  logic             r_encrypt;
  logic [BLK_W-1:0] r_core_din;
  logic             r_core_encrypt;
  logic [BLK_W-1:0] r_out_data;

  logic [1:0]       w_nx_mode;
  logic             w_nx_enc;
  logic [BLK_W-1:0] w_nx_chain;
  logic [BLK_W-1:0] w_issue_din;
  logic             w_issue_enc;
  logic [CTR_W-1:0] w_ctr_low;
  logic [BLK_W-1:0] w_ctr_next;
  logic [BLK_W-1:0] w_result;
  logic [BLK_W-1:0] w_chain_upd;
  logic             w_done_ok;
  logic             w_out_hs;

  // Input buffer
  assign w_full       = (r_count == FIFO_FULL);
  assign w_empty      = (r_count == '0);
  assign w_push       = in_valid && !w_full;
  assign w_head       = r_fifo_mem[r_rd_ptr];
  assign w_head_first = w_head[BLK_W];
  assign w_head_data  = w_head[BLK_W-1:0];
  assign in_ready     = !w_full;

  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= {in_first, in_data};
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (core_done) w_state_nxt = S_OUT;
      S_OUT:   if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_pop     = 1'b0;
    core_req  = 1'b0;
    out_valid = 1'b0;
    w_done_ok = 1'b0;
    w_out_hs  = 1'b0;
    case (r_state)
      S_IDLE:  w_pop = !w_empty;
      S_ISSUE: core_req = 1'b1;
      S_WAIT:  w_done_ok = core_done;
      S_OUT: begin
        out_valid = 1'b1;
        w_out_hs  = out_ready;
      end
      default: ;
    endcase
  end

  // Core input is computed from the values that will be live after the pop,
  // so it is registered and stable from the core_req cycle onward.
  always_comb begin
    w_nx_mode   = w_head_first ? mode    : r_mode;
    w_nx_enc    = w_head_first ? encrypt : r_encrypt;
    w_nx_chain  = w_head_first ? iv      : r_chain;
    w_issue_din = w_head_data;
    w_issue_enc = w_nx_enc;
    case (w_nx_mode)
      M_ECB: w_issue_din = w_head_data;
      M_CBC: w_issue_din = w_nx_enc ? (w_head_data ^ w_nx_chain) : w_head_data;
      M_CTR, M_OFB: begin
        w_issue_din = w_nx_chain;
        w_issue_enc = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_ctr_low  = r_chain[CTR_W-1:0] + CTR_W'(1);
  assign w_ctr_next = (r_chain & ~CTR_MASK) | BLK_W'(w_ctr_low);

  always_comb begin
    w_result    = core_dout;
    w_chain_upd = r_chain;
    case (r_mode)
      M_ECB: w_result = core_dout;
      M_CBC: begin
        if (r_encrypt) begin
          w_result    = core_dout;
          w_chain_upd = core_dout;
        end else begin
          w_result    = core_dout ^ r_chain;
          w_chain_upd = r_work;
        end
      end
      M_CTR: begin
        w_result    = r_work ^ core_dout;
        w_chain_upd = w_ctr_next;
      end
      M_OFB: begin
        w_result    = r_work ^ core_dout;
        w_chain_upd = core_dout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_work         <= '0;
      r_work_first   <= 1'b0;
      r_chain        <= '0;
      r_mode         <= M_ECB;
      r_encrypt      <= 1'b0;
      r_core_din     <= '0;
      r_core_encrypt <= 1'b0;
      r_out_data     <= '0;
    end else begin
      if (w_pop) begin
        r_work         <= w_head_data;
        r_work_first   <= w_head_first;
        r_mode         <= w_nx_mode;
        r_encrypt      <= w_nx_enc;
        r_chain        <= w_nx_chain;
        r_core_din     <= w_issue_din;
        r_core_encrypt <= w_issue_enc;
      end
      if (w_done_ok) begin
        r_out_data <= w_result;
        r_chain    <= w_chain_upd;
      end
    end
  end

  assign core_din     = r_core_din;
  assign core_encrypt = r_core_encrypt;
  assign out_data     = r_out_data;

`ifdef IBR_OPMODE_CNT_EN
  logic [15:0] r_blk_cnt;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_blk_cnt <= '0;
    end else if (w_out_hs) begin
      if (r_work_first) begin
        r_blk_cnt <= 16'd1;
      end else if (r_blk_cnt != 16'hFFFF) begin
        r_blk_cnt <= r_blk_cnt + 16'd1;
      end
    end
  end

  assign blk_cnt = r_blk_cnt;
`else
  logic w_unused_cnt;
  assign w_unused_cnt = w_out_hs ^ r_work_first;
`endif

endmodule

// File: tb/tb_ibr_opmode_stream.sv
// Directed bench for ibr_opmode_stream with an XOR cipher-core stub (4-cycle latency).
// Exercises blk_cnt as well when built with IBR_OPMODE_CNT_EN.
module tb_ibr_opmode_stream;

  localparam logic [127:0] K  = {16{8'h5A}};
  localparam logic [127:0] P  = 128'h1234_56ab_cd13_2536_1234_56ab_cd13_2536;
  localparam logic [127:0] IV = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         in_first = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic         encrypt = 1'b0;
  logic [127:0] iv = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         core_req;
  logic         core_encrypt;
  logic [127:0] core_din;
  logic [127:0] core_dout = '0;
  logic         core_done = 1'b0;
`ifdef IBR_OPMODE_CNT_EN
  logic [15:0]  blk_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  ibr_opmode_stream #(.BLK_W(128), .CTR_W(32), .FIFO_DEPTH(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_first(in_first),
    .mode(mode), .encrypt(encrypt), .iv(iv),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_req(core_req), .core_encrypt(core_encrypt), .core_din(core_din),
    .core_dout(core_dout), .core_done(core_done)
`ifdef IBR_OPMODE_CNT_EN
    , .blk_cnt(blk_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  // Core stub: dout = din ^ 5A.., done pulses 4 cycles after the req edge.
  logic [2:0]   stub_cnt = '0;
  logic [127:0] stub_din = '0;
  always @(posedge Clk) begin
    core_done <= 1'b0;
    if (core_req) begin
      stub_cnt <= 3'd4;
      stub_din <= core_din;
    end else if (stub_cnt != 3'd0) begin
      stub_cnt <= stub_cnt - 3'd1;
      if (stub_cnt == 3'd1) begin
        core_done <= 1'b1;
        core_dout <= stub_din ^ K;
      end
    end
  end

  logic [127:0] last_din = '1;
  logic         last_enc = 1'b0;
  always @(negedge Clk) begin
    if (core_req) begin
      last_din = core_din;
      last_enc = core_encrypt;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_blk(input logic [127:0] d, input logic f);
    int t;
    @(negedge Clk);
    in_valid = 1'b1;
    in_data  = d;
    in_first = f;
    t = 0;
    while (!in_ready && t < 300) begin
      @(negedge Clk);
      t++;
    end
    if (!in_ready) check("push_timeout", {127'd0, in_ready}, 128'd1);
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic get_out(output logic [127:0] d);
    int t;
    t = 0;
    @(negedge Clk);
    while (!out_valid && t < 300) begin
      @(negedge Clk);
      t++;
    end
    if (!out_valid) check("out_timeout", {127'd0, out_valid}, 128'd1);
    d = out_data;
    out_ready = 1'b1;
    @(posedge Clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] got, got2, c1, c2, d1, d2, ctr_iv;
    logic [127:0] bp [6];
    logic [127:0] bp_got [6];
    int n, req_cnt, bad;

    repeat (3) @(negedge Clk);
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_core_req", {127'd0, core_req}, 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_core_din", core_din, 128'd0);
    check("rst_core_enc", {127'd0, core_encrypt}, 128'd0);
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);
`ifdef IBR_OPMODE_CNT_EN
    check("rst_blk_cnt", {112'd0, blk_cnt}, 128'd0);
`endif
    Rst = 1'b0;
    repeat (2) @(negedge Clk);

    // ECB encrypt of zero, latency from pop cycle
    mode = 2'd0; encrypt = 1'b1; iv = '0;
    push_blk(128'd0, 1'b1);
    n = 0; req_cnt = 0;
    while (!out_valid && n < 50) begin
      @(negedge Clk);
      n++;
      if (core_req) req_cnt++;
    end
    check("ecb_latency", 128'(n - 1), 128'd7);
    check("ecb_req_pulses", 128'(req_cnt), 128'd1);
    check("ecb_core_din", last_din, 128'd0);
    check("ecb_core_enc", {127'd0, last_enc}, 128'd1);
    get_out(got);
    check("ecb_out", got, K);

    // CBC encrypt, two blocks
    mode = 2'd1; encrypt = 1'b1; iv = IV;
    push_blk(P, 1'b1);
    push_blk(P, 1'b0);
    get_out(c1);
    get_out(c2);
    check("cbc_enc_c1", c1, P ^ IV ^ K);
    check("cbc_enc_c2", c2, P ^ (P ^ IV ^ K) ^ K);

    // CBC decrypt back to plaintext
    encrypt = 1'b0;
    push_blk(c1, 1'b1);
    push_blk(c2, 1'b0);
    get_out(got);
    get_out(got2);
    check("cbc_dec_p1", got, P);
    check("cbc_dec_p2", got2, P);
    check("cbc_dec_enc", {127'd0, last_enc}, 128'd0);

    // CTR with low counter wrap
    mode = 2'd2; encrypt = 1'b0;
    ctr_iv = 128'hA5A5_0001_C3C3_0002_9696_0003_FFFF_FFFF;
    iv = ctr_iv;
    d1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    d2 = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
    push_blk(d1, 1'b1);
    push_blk(d2, 1'b0);
    get_out(got);
    get_out(got2);
    check("ctr_b1", got, d1 ^ ctr_iv ^ K);
    check("ctr_b2", got2, d2 ^ 128'hA5A5_0001_C3C3_0002_9696_0003_0000_0000 ^ K);
    check("ctr_core_enc", {127'd0, last_enc}, 128'd1);

    // OFB two blocks, then a third with mode/encrypt changed but no first flag
    mode = 2'd3; encrypt = 1'b1; iv = IV;
    push_blk(d1, 1'b1);
    push_blk(d2, 1'b0);
    get_out(got);
    get_out(got2);
    check("ofb_b1", got, d1 ^ IV ^ K);
    check("ofb_b2", got2, d2 ^ IV);
    mode = 2'd0; encrypt = 1'b0;
    push_blk(P, 1'b0);
    get_out(got);
    check("ofb_mode_ignored", got, P ^ IV ^ K);

    // consecutive first blocks restart from iv
    mode = 2'd3; iv = IV;
    push_blk(d1, 1'b1);
    push_blk(d1, 1'b1);
    get_out(got);
    get_out(got2);
    check("restart_b1", got, d1 ^ IV ^ K);
    check("restart_b2", got2, d1 ^ IV ^ K);

    // backpressure: 6 ECB blocks with out_ready low
    mode = 2'd0; encrypt = 1'b1;
    for (int i = 0; i < 6; i++) bp[i] = {96'h0, 32'(i + 1)} ^ {16{8'h3C}};
    for (int i = 0; i < 4; i++) push_blk(bp[i], i == 0);
    check("bp_ready_3_buf", {127'd0, in_ready}, 128'd1);
    push_blk(bp[4], 1'b0);
    check("bp_ready_full", {127'd0, in_ready}, 128'd0);
    bad = 0;
    repeat (20) begin
      @(negedge Clk);
      if (out_valid && out_data !== (bp[0] ^ K)) bad++;
    end
    check("bp_out_valid", {127'd0, out_valid}, 128'd1);
    check("bp_out_stable", 128'(bad), 128'd0);
    check("bp_still_full", {127'd0, in_ready}, 128'd0);
    fork
      push_blk(bp[5], 1'b0);
      for (int j = 0; j < 6; j++) get_out(bp_got[j]);
    join
    for (int j = 0; j < 6; j++) check($sformatf("bp_order_%0d", j), bp_got[j], bp[j] ^ K);

    // reset during WAIT
    mode = 2'd1; encrypt = 1'b1; iv = IV;
    push_blk(P, 1'b1);
    n = 0;
    while (!core_req && n < 50) begin
      @(negedge Clk);
      n++;
    end
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    #1;
    check("rstw_out_valid", {127'd0, out_valid}, 128'd0);
    check("rstw_core_din", core_din, 128'd0);
    @(negedge Clk);
    Rst = 1'b0;
    bad = 0;
    repeat (12) begin
      @(negedge Clk);
      if (out_valid) bad++;
    end
    check("rstw_late_done", 128'(bad), 128'd0);
    push_blk(P, 1'b1);
    get_out(got);
    check("rstw_recover", got, P ^ IV ^ K);

`ifdef IBR_OPMODE_CNT_EN
    mode = 2'd3; iv = IV;
    push_blk(d1, 1'b1);
    push_blk(d2, 1'b0);
    push_blk(P, 1'b0);
    get_out(got);
    check("cnt_1", {112'd0, blk_cnt}, 128'd1);
    get_out(got);
    check("cnt_2", {112'd0, blk_cnt}, 128'd2);
    get_out(got);
    check("cnt_3", {112'd0, blk_cnt}, 128'd3);
    push_blk(d1, 1'b1);
    get_out(got);
    check("cnt_new_msg", {112'd0, blk_cnt}, 128'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ibr_opmode_stream.md
Name: ibr_opmode_stream

Overview:
Parametrised streaming mode-of-operation engine for the IBR block-cipher family.
- Sits between a valid/ready data stream and an external block-cipher core. Drives that core through a single-request/done handshake.
- Supports ECB, CBC, CTR and OFB across multi-block messages.
- Adds input buffering and backpressure on both stream sides.
- Successor to the fixed 128-bit, single-block opmode logic.

Parameters:
BLK_W, 128, cipher block width in bits; must be a multiple of 64.
CTR_W, 32, width of the low counter field incremented in CTR mode; 1..BLK_W.
FIFO_DEPTH, 4, input buffer depth in blocks; power of 2, at least 2.

Ports:
Clk  in  1  clock; all logic on rising edge.
Rst  in  1  asynchronous, active-high reset.
in_valid  in  1  input block valid.
in_ready  out  1  input buffer can accept a block.
in_data  in  BLK_W  plaintext (encrypt) or ciphertext (decrypt).
in_first  in  1  block starts a new message; captured with in_data.
mode  in  2  0 ECB, 1 CBC, 2 CTR, 3 OFB; sampled with first block.
encrypt  in  1  1 encrypt, 0 decrypt; sampled with first block.
iv  in  BLK_W  IV / initial counter; sampled when a first block is processed.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts result.
out_data  out  BLK_W  result block.
core_req  out  1  one-cycle start pulse to the cipher core.
core_encrypt  out  1  core direction.
core_din  out  BLK_W  core input block, held stable from core_req until core_done.
core_dout  in  BLK_W  core output, valid when core_done=1.
core_done  in  1  one-cycle completion pulse from the core.

Behaviour:
Reset:
- Outputs: out_valid=0, core_req=0, out_data=0, core_din=0, core_encrypt=0.
- Internal: FIFO empty, chain register=0, stored mode=ECB, FSM=IDLE.
- Reset mid-operation aborts the block in flight. A core_done arriving afterwards in IDLE is ignored.

FIFO:
- Stores {in_first, in_data}.
- in_ready = !full. A push on a full FIFO is impossible by construction.
- Push and pop in the same cycle are allowed when not full.

FSM: IDLE -> ISSUE -> WAIT -> OUT -> IDLE
- IDLE: when FIFO is non-empty, pop the head into the working register and go to ISSUE.
  - If the head has in_first=1: latch mode, encrypt and iv into the chain register.
  - A first block with no prior message uses the same path.
- ISSUE: assert core_req for exactly 1 cycle with core_din/core_encrypt set per mode; go to WAIT.
- WAIT: hold core_din. When core_done is sampled, compute the result, register it to out_data, update the chain register, go to OUT.
- OUT: out_valid=1 with out_data stable until out_valid && out_ready; then go to IDLE.
- Minimum latency, pop to out_valid: 3 cycles plus core latency.

Mode rules (P/C = working block, X = chain register):
- ECB: din=P, core_encrypt=encrypt, out=dout. X unused.
- CBC encrypt: din=P^X, out=dout, X<=dout.
- CBC decrypt: din=C, out=dout^X, X<=C.
- CTR: din=X, core_encrypt=1, out=in^dout. X[CTR_W-1:0]<=X[CTR_W-1:0]+1, wrapping mod 2^CTR_W; upper bits never change.
- OFB: din=X, core_encrypt=1, out=in^dout, X<=dout.

Boundary conditions:
- in_first=1 on consecutive blocks restarts from iv each time.
- A mode or encrypt change without in_first is ignored.
- core_done outside WAIT is ignored.

Optional Feature:
IBR_OPMODE_CNT_EN
- Defined: adds output port blk_cnt[15:0].
  - Reset 0. Loads 1 when a first block completes. Otherwise increments on each out_valid && out_ready handshake.
  - Saturates at 16'hFFFF.
- Undefined: no port, no counter logic. Data behaviour identical.

Test Plan:
Bench core stub: dout = din ^ {BLK_W/8{8'h5A}}, 4-cycle latency. BLK_W=128.
- ECB encrypt, in_data=0, in_first=1, out_ready=1 -> out_data=5A5A...5A; out_valid exactly 7 cycles after pop.
- CBC encrypt, 2 blocks P=1234_56ab_cd13_2536_1234_56ab_cd13_2536, iv=1111_2222_..._8888 -> C1=P^iv^5A..; C2=P^C1^5A... Decrypting C1,C2 with the same iv returns P,P.
- CTR, iv low 32 bits=FFFF_FFFF, 2 blocks -> block 2 keystream uses counter low 32=0000_0000 with upper 96 bits unchanged; out=in^ctr^5A..
- Backpressure: out_ready=0 for 20 cycles while pushing 6 blocks, FIFO_DEPTH=4 -> in_ready drops once 4 blocks are buffered; out_data stable; no block lost or reordered.
- Rst asserted during WAIT -> out_valid=0 immediately; the late core_done is ignored; the next first block processes correctly from iv.
- With IBR_OPMODE_CNT_EN: 3-block OFB message -> blk_cnt reads 1, 2, 3; a new in_first block -> blk_cnt=1.
